// File: rtl/mem_port_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one single-port memory,
// one command in flight at a time, with a bounded starvation guard for fetches.
module mem_port_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        if_req_i,
   input  logic [31:0] if_addr_i,
   output logic [31:0] if_rdata_o,
   output logic        if_ack_o,
   input  logic        dm_req_i,
   input  logic        dm_we_i,
   input  logic [31:0] dm_addr_i,
   input  logic [31:0] dm_wdata_i,
   output logic [31:0] dm_rdata_o,
   output logic        dm_ack_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic [31:0] mem_rdata_i,
   input  logic        mem_ready_i,
   output logic        stall_if_o,
   output logic        stall_mem_o
);

   typedef enum logic [1:0] {IDLE, FETCH, DATA} state_e;

   localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

   state_e      state_q, state_d;
   logic [2:0]  starve_q, starve_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic        if_ack_q, if_ack_d;
   logic        dm_ack_q, dm_ack_d;
   logic [31:0] if_rdata_q, if_rdata_d;
   logic [31:0] dm_rdata_q, dm_rdata_d;
   logic        if_elig, dm_elig;

   // A requester sitting in its ack cycle is still holding req; it must not be re-served.
   assign if_elig = if_req_i & ~if_ack_q;
   assign dm_elig = dm_req_i & ~dm_ack_q;

   always_comb begin
      state_d     = state_q;
      starve_d    = starve_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if_ack_d    = 1'b0;
      dm_ack_d    = 1'b0;
      if_rdata_d  = if_rdata_q;
      dm_rdata_d  = dm_rdata_q;
      case (state_q)
         IDLE: begin
            if (if_elig && (!dm_elig || starve_q == LIMIT)) begin
               state_d    = FETCH;
               mem_we_d   = 1'b0;
               mem_addr_d = if_addr_i;
               starve_d   = 3'd0;
            end else if (dm_elig) begin
               state_d     = DATA;
               mem_we_d    = dm_we_i;
               mem_addr_d  = dm_addr_i;
               mem_wdata_d = dm_wdata_i;
               if (if_elig && starve_q != LIMIT) starve_d = starve_q + 3'd1;
            end
         end
         FETCH: begin
            if (mem_ready_i) begin
               state_d    = IDLE;
               if_ack_d   = 1'b1;
               if_rdata_d = mem_rdata_i;
            end
         end
         DATA: begin
            if (mem_ready_i) begin
               state_d  = IDLE;
               dm_ack_d = 1'b1;
               if (!mem_we_q) dm_rdata_d = mem_rdata_i;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         starve_q    <= 3'd0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 32'd0;
         mem_wdata_q <= 32'd0;
         if_ack_q    <= 1'b0;
         dm_ack_q    <= 1'b0;
         if_rdata_q  <= 32'd0;
         dm_rdata_q  <= 32'd0;
      end else begin
         state_q     <= state_d;
         starve_q    <= starve_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_ack_q    <= if_ack_d;
         dm_ack_q    <= dm_ack_d;
         if_rdata_q  <= if_rdata_d;
         dm_rdata_q  <= dm_rdata_d;
      end
   end

   assign mem_req_o   = (state_q != IDLE);
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;
   assign if_ack_o    = if_ack_q;
   assign dm_ack_o    = dm_ack_q;
   assign if_rdata_o  = if_rdata_q;
   assign dm_rdata_o  = dm_rdata_q;
   assign stall_if_o  = if_req_i & ~if_ack_q;
   assign stall_mem_o = dm_req_i & ~dm_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios then random traffic, all checked
// against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;

   localparam int SL = 1;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req, dm_req, dm_we, mem_ready;
   logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
   logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
   logic        if_ack, dm_ack, mem_req, mem_we, stall_if, stall_mem;

   int passed = 0;
   int total  = 0;

   // model: one optional outstanding command plus pending ack/read-data values
   bit          m_busy, m_fetch, m_we, m_ifa, m_dma, last_ifa, last_dma;
   logic [31:0] m_addr, m_wdata, m_ifr, m_dmr;
   int          m_starve;

   always #5 clk = ~clk;

   mem_port_arbiter #(.STARVE_LIMIT(SL)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata), .if_ack_o(if_ack),
      .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
      .dm_rdata_o(dm_rdata), .dm_ack_o(dm_ack),
      .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
      .mem_rdata_i(mem_rdata), .mem_ready_i(mem_ready),
      .stall_if_o(stall_if), .stall_mem_o(stall_mem)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   function automatic void m_reset();
      m_busy = 0; m_fetch = 0; m_we = 0; m_ifa = 0; m_dma = 0;
      m_addr = '0; m_wdata = '0; m_ifr = '0; m_dmr = '0; m_starve = 0;
   endfunction

   function automatic void m_step();
      bit fe, de, nifa, ndma;
      nifa = 0; ndma = 0;
      fe = if_req && !m_ifa;
      de = dm_req && !m_dma;
      if (!m_busy) begin
         if (fe && (!de || m_starve == SL)) begin
            m_busy = 1; m_fetch = 1; m_we = 0; m_addr = if_addr; m_starve = 0;
         end else if (de) begin
            m_busy = 1; m_fetch = 0; m_we = dm_we; m_addr = dm_addr; m_wdata = dm_wdata;
            if (fe && m_starve < SL) m_starve++;
         end
      end else if (mem_ready) begin
         m_busy = 0;
         if (m_fetch) begin nifa = 1; m_ifr = mem_rdata; end
         else begin ndma = 1; if (!m_we) m_dmr = mem_rdata; end
      end
      m_ifa = nifa; m_dma = ndma;
   endfunction

   task automatic check_all();
      chk("mem_req", mem_req, m_busy);
      chk("mem_we", mem_we, m_we);
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_wdata", mem_wdata, m_wdata);
      chk("if_ack", if_ack, m_ifa);
      chk("dm_ack", dm_ack, m_dma);
      chk("if_rdata", if_rdata, m_ifr);
      chk("dm_rdata", dm_rdata, m_dmr);
      chk("stall_if", stall_if, if_req & ~m_ifa);
      chk("stall_mem", stall_mem, dm_req & ~m_dma);
      chk("acks_exclusive", if_ack & dm_ack, 1'b0);
   endtask

   task automatic sample();
      #4;
      check_all();
   endtask

   task automatic adv();
      last_ifa = m_ifa; last_dma = m_dma;
      m_step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      if_req = 0; dm_req = 0; dm_we = 0; mem_ready = 0;
      if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
      m_reset(); last_ifa = 0; last_dma = 0;

      // reset with random inputs
      for (int i = 0; i < 6; i++) begin
         if_req = 1'($urandom); dm_req = 1'($urandom); dm_we = 1'($urandom);
         mem_ready = 1'($urandom); if_addr = $urandom; dm_addr = $urandom;
         dm_wdata = $urandom; mem_rdata = $urandom;
         #4;
         check_all();
         @(posedge clk);
         #1;
      end
      if_req = 0; dm_req = 0; mem_ready = 1;
      rst_n = 1'b1;

      // single fetch with zero wait states
      if_req = 1; if_addr = 32'h100; mem_rdata = 32'h2010000A;
      sample(); chk("f0_stall_if", stall_if, 1'b1); adv();
      sample(); chk("f1_mem_req", mem_req, 1'b1); chk("f1_addr", mem_addr, 32'h100);
      chk("f1_we", mem_we, 1'b0); adv();
      sample(); chk("f2_if_ack", if_ack, 1'b1); chk("f2_if_rdata", if_rdata, 32'h2010000A); adv();
      if_req = 0;
      sample(); adv();

      // simultaneous fetch and load: data first, fetch granted on the ack cycle
      if_req = 1; if_addr = 32'h204; dm_req = 1; dm_we = 0; dm_addr = 32'h40;
      mem_rdata = 32'hCAFE0001;
      sample(); adv();
      sample(); chk("s1_addr", mem_addr, 32'h40); chk("s1_we", mem_we, 1'b0); adv();
      mem_rdata = 32'h13000093;
      sample(); chk("s2_dm_ack", dm_ack, 1'b1); chk("s2_dm_rdata", dm_rdata, 32'hCAFE0001);
      chk("s2_if_ack", if_ack, 1'b0); adv();
      dm_req = 0;
      sample(); chk("s3_addr", mem_addr, 32'h204); chk("s3_mem_req", mem_req, 1'b1); adv();
      sample(); chk("s4_if_ack", if_ack, 1'b1); chk("s4_if_rdata", if_rdata, 32'h13000093); adv();
      if_req = 0;
      sample(); adv();

      // store with three wait states
      dm_req = 1; dm_we = 1; dm_addr = 32'h80; dm_wdata = 32'h55; mem_ready = 0;
      sample(); adv();
      for (int i = 0; i < 4; i++) begin
         mem_ready = (i == 3);
         mem_rdata = $urandom;
         sample();
         chk("w_mem_req", mem_req, 1'b1); chk("w_we", mem_we, 1'b1);
         chk("w_addr", mem_addr, 32'h80); chk("w_wdata", mem_wdata, 32'h55);
         chk("w_stall_mem", stall_mem, 1'b1); chk("w_dm_ack", dm_ack, 1'b0);
         adv();
      end
      sample(); chk("w_dm_ack_end", dm_ack, 1'b1); chk("w_dm_rdata_kept", dm_rdata, 32'hCAFE0001);
      adv();
      dm_req = 0;
      sample(); adv();

      // reset during a data wait state
      dm_req = 1; dm_we = 0; dm_addr = 32'h3C0; mem_ready = 0;
      sample(); adv();
      sample(); chk("r_mem_req_before", mem_req, 1'b1);
      #2 rst_n = 1'b0;
      #1 m_reset();
      chk("r_mem_req_async", mem_req, 1'b0);
      chk("r_addr_async", mem_addr, 32'h0);
      chk("r_dm_rdata_async", dm_rdata, 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1; mem_ready = 1; mem_rdata = 32'h0BADF00D;
      sample(); chk("r_no_ack", dm_ack, 1'b0); adv();
      sample(); chk("r_regrant", mem_addr, 32'h3C0); adv();
      sample(); chk("r_ack_new", dm_ack, 1'b1); chk("r_rdata_new", dm_rdata, 32'h0BADF00D); adv();
      dm_req = 0;
      sample(); adv();

      // random traffic, mostly protocol-conformant with occasional dropped requests
      for (int i = 0; i < 3000; i++) begin
         if (!if_req || last_ifa) begin
            if_req = ($urandom_range(3) != 0); if_addr = $urandom;
         end else if ($urandom_range(31) == 0) if_req = 0;
         if (!dm_req || last_dma) begin
            dm_req = ($urandom_range(3) != 0); dm_we = 1'($urandom);
            dm_addr = $urandom; dm_wdata = $urandom;
         end else if ($urandom_range(31) == 0) dm_req = 0;
         mem_ready = ($urandom_range(3) != 0);
         mem_rdata = $urandom;
         sample();
         adv();
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
